// File: rtl/tdm_demux.sv
// tdm_demux
//   Receive side of the serial TDM link. Hunts for the frame sync marker,
//   deserializes NUM_CH slots of SLOT_W bits (slot 0 first, MSB first) into
//   a shadow register and publishes each complete frame atomically.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   z            serial data bit
//   en           qualifies z/sync; a bit is consumed only when en=1
//   sync         high with en on the first bit of a frame
//   ch_data      last complete frame, slot k at [k*SLOT_W +: SLOT_W]
//   frame_valid  one-cycle pulse: ch_data just updated
//   sync_err     one-cycle pulse: missing or early sync detected
//   locked       high while frame alignment is held
module tdm_demux #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SLOT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       z,
    input  logic                       en,
    input  logic                       sync,
    output logic [NUM_CH*SLOT_W-1:0]   ch_data,
    output logic                       frame_valid,
    output logic                       sync_err,
    output logic                       locked
);

    localparam int unsigned FRAME_W = NUM_CH * SLOT_W;
    localparam int unsigned CW      = $clog2(FRAME_W);
    localparam logic [CW-1:0] LAST  = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME_W-1:0]   shadow_q, shadow_d;
    logic [FRAME_W-1:0]   ch_data_q, ch_data_d;
    logic                 fv_q, fv_d;
    logic                 se_q, se_d;

    // Bit index within the frame -> position in the shadow register
    // (slots are stored LSB-slot first, but each slot arrives MSB first).
    function automatic logic [CW-1:0] pos_of(input logic [CW-1:0] b);
        int unsigned bi;
        bi = 32'(b);
        return CW'((bi / SLOT_W) * SLOT_W + (SLOT_W - 1) - (bi % SLOT_W));
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        ch_data_d = ch_data_q;
        fv_d      = 1'b0;
        se_d      = 1'b0;

        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        shadow_d[pos_of('0)] = z;
                        cnt_d                = ONE;
                        state_d              = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // Sync mid-frame abandons the partial frame but
                        // still starts a new one with this bit.
                        se_d                 = (cnt_q != '0);
                        shadow_d[pos_of('0)] = z;
                        cnt_d                = ONE;
                    end else if (cnt_q == '0) begin
                        se_d    = 1'b1;
                        state_d = HUNT;
                    end else begin
                        shadow_d[pos_of(cnt_q)] = z;
                        if (cnt_q == LAST) begin
                            cnt_d     = '0;
                            ch_data_d = shadow_d;
                            fv_d      = 1'b1;
                        end else begin
                            cnt_d = cnt_q + ONE;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            cnt_q     <= '0;
            shadow_q  <= '0;
            ch_data_q <= '0;
            fv_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            ch_data_q <= ch_data_d;
            fv_q      <= fv_d;
            se_q      <= se_d;
        end
    end

    assign ch_data     = ch_data_q;
    assign frame_valid = fv_q;
    assign sync_err    = se_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
`timescale 1ns/100ps
module tb_tdm_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        z, en, sync;
    logic [31:0] ch_data;
    logic        frame_valid, sync_err, locked;

    int checks   = 0;
    int failures = 0;
    int fv_cnt   = 0;
    int se_cnt   = 0;

    // reference model state
    bit          m_locked;
    int          m_cnt;
    bit          m_bits[32];
    logic [31:0] m_data;
    bit          m_fv, m_se;

    tdm_demux #(.NUM_CH(4), .SLOT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .z(z), .en(en), .sync(sync),
        .ch_data(ch_data), .frame_valid(frame_valid),
        .sync_err(sync_err), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_cnt = 0; m_data = '0; m_fv = 0; m_se = 0;
        foreach (m_bits[i]) m_bits[i] = 0;
    endtask

    // Frame bits arrive in order; bit n belongs to slot n/8, MSB first.
    function automatic logic [31:0] pack_frame();
        logic [31:0] w;
        w = '0;
        for (int n = 0; n < 32; n++)
            if (m_bits[n]) w = w | (32'h80 << ((n / 8) * 8)) >> (n % 8);
        return w;
    endfunction

    task automatic model_step(input bit e, input bit s, input bit d);
        m_fv = 0; m_se = 0;
        if (!e) return;
        if (!m_locked) begin
            if (s) begin m_bits[0] = d; m_cnt = 1; m_locked = 1; end
        end else if (s) begin
            if (m_cnt != 0) m_se = 1;
            m_bits[0] = d; m_cnt = 1;
        end else if (m_cnt == 0) begin
            m_se = 1; m_locked = 0;
        end else begin
            m_bits[m_cnt] = d;
            m_cnt++;
            if (m_cnt == 32) begin
                m_cnt = 0; m_fv = 1; m_data = pack_frame();
            end
        end
    endtask

    task automatic step(input logic e, input logic s, input logic d);
        @(negedge clk);
        en = e; sync = s; z = d;
        @(posedge clk);
        model_step(e, s, d);
        #1;
        check("locked",      32'(locked),      32'(m_locked));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("sync_err",    32'(sync_err),    32'(m_se));
        check("ch_data",     ch_data,          m_data);
        check("strobe_excl", 32'(frame_valid & sync_err), 32'd0);
        if (frame_valid) fv_cnt++;
        if (sync_err)    se_cnt++;
    endtask

    // Sends the first nbits of frame w (slot 0 = w[7:0], MSB first).
    task automatic send_frame(input logic [31:0] w, input bit sync0, input bit gap, input int nbits);
        logic [31:0] sh;
        for (int b = 0; b < nbits; b++) begin
            sh = w >> ((b / 8) * 8 + 7 - (b % 8));
            step(1'b1, (b == 0) ? sync0 : 1'b0, sh[0]);
            if (gap) step(1'b0, 1'b1, 1'($urandom));
        end
    endtask

    initial begin
        int pos;
        logic e, s;
        rst_n = 1'b0; en = 1'b0; sync = 1'b0; z = 1'b0;
        model_reset();
        #1;
        check("rst_ch_data", ch_data, 32'h0);
        check("rst_locked",  32'(locked), 32'd0);
        check("rst_fv",      32'(frame_valid), 32'd0);
        check("rst_se",      32'(sync_err), 32'd0);
        #11 rst_n = 1'b1;

        // single frame
        fv_cnt = 0; se_cnt = 0;
        send_frame(32'h01FF3CA5, 1'b1, 1'b0, 1);
        check("t1_locked_first", 32'(locked), 32'd1);
        send_frame(32'h01FF3CA5, 1'b0, 1'b0, 0);
        for (int b = 1; b < 32; b++) begin
            logic [31:0] sh;
            sh = 32'h01FF3CA5 >> ((b / 8) * 8 + 7 - (b % 8));
            step(1'b1, 1'b0, sh[0]);
        end
        step(1'b0, 1'b0, 1'b0);
        check("t1_ch_data", ch_data, 32'h01FF3CA5);
        check("t1_fv_pulses", 32'(fv_cnt), 32'd1);
        check("t1_se_pulses", 32'(se_cnt), 32'd0);

        // back-to-back with en gaps
        fv_cnt = 0;
        send_frame(32'h44332211, 1'b1, 1'b1, 32);
        check("t2_ch_data_a", ch_data, 32'h44332211);
        send_frame(32'hEFBEADDE, 1'b1, 1'b1, 32);
        check("t2_ch_data_b", ch_data, 32'hEFBEADDE);
        check("t2_fv_pulses", 32'(fv_cnt), 32'd2);

        // missing sync
        se_cnt = 0; fv_cnt = 0;
        send_frame(32'h12345678, 1'b0, 1'b0, 32);
        check("t3_se_pulses", 32'(se_cnt), 32'd1);
        check("t3_locked",    32'(locked), 32'd0);
        check("t3_ch_hold",   ch_data, 32'hEFBEADDE);
        send_frame(32'hAA55F00F, 1'b1, 1'b0, 32);
        check("t3_relock", ch_data, 32'hAA55F00F);
        check("t3_fv_pulses", 32'(fv_cnt), 32'd1);

        // early sync at bit 13
        se_cnt = 0; fv_cnt = 0;
        send_frame(32'h9999AAAA, 1'b1, 1'b0, 13);
        send_frame(32'h04030201, 1'b1, 1'b0, 32);
        check("t4_se_pulses", 32'(se_cnt), 32'd1);
        check("t4_fv_pulses", 32'(fv_cnt), 32'd1);
        check("t4_locked",    32'(locked), 32'd1);
        check("t4_ch_data",   ch_data, 32'h04030201);

        // asynchronous reset mid-frame
        send_frame(32'hCAFEBABE, 1'b1, 1'b0, 20);
        #1.5 rst_n = 1'b0; en = 1'b0;
        #0.5;
        model_reset();
        check("t5_ch_data", ch_data, 32'h0);
        check("t5_locked",  32'(locked), 32'd0);
        check("t5_fv",      32'(frame_valid), 32'd0);
        #2.5 rst_n = 1'b1;
        se_cnt = 0; fv_cnt = 0;
        for (int b = 0; b < 40; b++) step(1'b1, 1'b0, 1'($urandom));
        check("t6_locked", 32'(locked), 32'd0);
        check("t6_se_pulses", 32'(se_cnt), 32'd0);
        check("t6_fv_pulses", 32'(fv_cnt), 32'd0);

        // randomized stream with occasional missing/early syncs
        pos = 0;
        for (int i = 0; i < 3000; i++) begin
            e = ($urandom_range(3) != 0);
            s = 1'b0;
            if (e) begin
                s = (pos == 0) ? ($urandom_range(15) != 0) : ($urandom_range(63) == 0);
                pos = s ? 1 : (pos + 1) % 32;
            end else begin
                s = 1'($urandom);
            end
            step(e, s, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL timeout: simulation exceeded time budget");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the team's 2:1 select/time-multiplex datapath: recovers N parallel channels from a single-bit time-division-multiplexed stream.
- The stream carries a frame sync marker; the block hunts for sync, deserializes slots into a shadow register, and publishes a complete frame atomically with a one-cycle strobe.
- Sits between the serial link input and the per-channel consumers; sync faults are flagged and force re-acquisition.

Parameters:
- NUM_CH, 4, number of channels (slots) per frame; legal 2..16
- SLOT_W, 8, bits per slot; legal 1..32

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- z  input  1  serial TDM data bit
- en  input  1  z/sync qualify; a bit is consumed only on cycles with en=1
- sync  input  1  high with en on the first bit of a frame (slot 0, MSB)
- ch_data  output  NUM_CH*SLOT_W  last complete frame; slot k at [k*SLOT_W +: SLOT_W]
- frame_valid  output  1  one-cycle pulse: ch_data just updated
- sync_err  output  1  one-cycle pulse: sync protocol violation detected
- locked  output  1  high while in LOCKED state

Behaviour:
- Reset (rst_n=0, asynchronous): state=HUNT, bit counter=0, shadow=0, ch_data=0, frame_valid=0, sync_err=0, locked=0. Deassertion is synchronous to clk.
- Cycles with en=0: no state, counter or data change; sync and z are ignored; strobes still return to 0.
- Bit order: slot 0 first, MSB first within a slot. Bit index b (0..NUM_CH*SLOT_W-1) writes shadow[(b/SLOT_W)*SLOT_W + SLOT_W-1-(b%SLOT_W)].
- Counter width: $clog2(NUM_CH*SLOT_W); wraps from last index to 0.
- HUNT state:
  - en=1, sync=0: bit discarded.
  - en=1, sync=1: z stored as bit 0; counter=1; go LOCKED.
  - No sync_err is raised in HUNT.
- LOCKED state, en=1:
  - Counter>0, sync=0: store bit; counter+1.
  - Counter=last index, sync=0: store bit; on the same edge copy the completed shadow (including this bit) to ch_data; frame_valid=1 the following cycle; counter=0.
  - Counter=0, sync=1: normal frame start; store bit 0; counter=1.
  - Counter=0, sync=0: missing sync. Bit discarded; sync_err=1 next cycle; go HUNT; locked=0 next cycle.
  - Counter>0, sync=1: early sync. Partial frame abandoned (ch_data unchanged, no frame_valid); sync_err=1 next cycle; bit stored as bit 0; counter=1; stay LOCKED.
- Latency: ch_data and frame_valid update one cycle after the clock edge that samples the last bit of a frame. ch_data holds its value between frames.
- Shadow bits not yet written in the current frame retain their previous-frame values; ch_data only ever updates with a frame whose bits were all written in that frame.
- frame_valid and sync_err are never both high in the same cycle.
- Reset mid-frame: partial frame lost; ch_data clears to 0; block re-hunts.

Test Plan (NUM_CH=4, SLOT_W=8):
- Reset, then sync on bit 0 and 32 contiguous en bits carrying slots 0xA5,0x3C,0xFF,0x01 -> locked=1 after the first bit; one frame_valid pulse; ch_data=32'h01FF3CA5; sync_err never asserted.
- Two back-to-back frames (0x11,0x22,0x33,0x44 then 0xDE,0xAD,0xBE,0xEF), en toggled 1/0 each cycle -> frame_valid pulses exactly twice; ch_data=32'h44332211, then 32'hEFBEADDE; gaps cause no state change.
- Frame 1 valid, then frame 2 with sync=0 on its first bit -> sync_err one pulse; locked=0; ch_data stays at frame 1 value; a later sync re-locks, and a full 32-bit frame of 0x0F,0xF0,0x55,0xAA gives ch_data=32'hAA55F00F.
- Sync reasserted at bit 13 of a frame, followed by a complete 32-bit frame of 0x01,0x02,0x03,0x04 -> sync_err pulse; no frame_valid for the abandoned frame; locked stays 1; next frame_valid with ch_data=32'h04030201.
- rst_n pulled low at bit 20 of a frame for a non-clock-aligned 3 ns -> ch_data=0, locked=0, frame_valid=0 immediately; bits without sync after release are ignored (locked stays 0).
- Bits streamed with sync=0 before any sync -> no sync_err, no frame_valid, locked=0.
